recur_seq_gen: RTL and testbench
================================

Name: recur_seq_gen

Overview:
- Parametrised second-order recurrence generator: each term is the sum of the previous two, i.e. t[n+2] = t[n+1] + t[n].
- Successor to the single-mode Fibonacci source. Adds programmable seeds (covers Fibonacci and Lucas sequences), three arithmetic modes (wrap, modular, stop-on-overflow), a term index, and a ready/valid output handshake with backpressure.
- Feeds sequence-driven modulation and pattern logic in the synth control path.

Parameters:
- SEQ_BITS, 32: term width in bits.
- IDX_BITS, 16: width of the term index counter.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- load, input, 1: one-cycle pulse. Captures seeds, mode and modulus, and restarts the sequence.
- seed0, input, SEQ_BITS: term t[0].
- seed1, input, SEQ_BITS: term t[1].
- mode, input, 2: 0 = wrap mod 2^SEQ_BITS; 1 = modulo `modulus`; 2 = stop on overflow; 3 = reserved, behaves as 0.
- modulus, input, SEQ_BITS: modulus for mode 1. A value of 0 means 2^SEQ_BITS.
- req, input, 1: request for the next term.
- req_ready, output, 1: the block can accept req this cycle.
- out_data, output, SEQ_BITS: emitted term.
- out_idx, output, IDX_BITS: index n of the emitted term.
- out_valid, output, 1: out_data and out_idx are valid.
- out_ready, input, 1: the consumer accepts the output.
- done, output, 1: stop mode only; all representable terms have been emitted.
- ovf, output, 1: sticky flag. A carry occurred in any mode since the last load or reset.

Behaviour:
- Internal state:
  - a: next term to emit. b: the term after it.
  - a_vld, b_vld: validity flags for a and b.
  - idx: index of a.
  - Config registers cfg_mode and cfg_mod, latched only at load.
- Reset (rst_n = 0 on a clock edge):
  - a = 0, b = 1, a_vld = b_vld = 1, idx = 0, cfg_mode = 0, cfg_mod = 0.
  - Outputs: out_valid = 0, out_data = 0, out_idx = 0, done = 0, ovf = 0.
  - Reset overrides everything, including mid-stall.
- Load:
  - Sets a = seed0, b = seed1, a_vld = b_vld = 1, idx = 0, and latches mode and modulus.
  - Clears out_valid, done and ovf. Any pending unaccepted output is dropped.
- Request acceptance:
  - req_ready = !load && a_vld && (!out_valid || out_ready).
  - An accepted request is req && req_ready.
- Latency: one cycle.
  - An accept at edge k registers out_data = a, out_idx = idx, out_valid = 1 at edge k.
  - Output is visible in the cycle after req is sampled.
- State advance on accept:
  - a <= b, a_vld <= b_vld, idx <= idx + 1 (wraps mod 2^IDX_BITS).
  - b <= f(a + b). The sum is computed at SEQ_BITS + 1 bits; the carry bit is c.
- Arithmetic function f:
  - Mode 0 (and 3): f = sum[SEQ_BITS-1:0].
  - Mode 1: f = sum − cfg_mod if sum ≥ cfg_mod, else sum.
    - cfg_mod = 0 gives the same result as mode 0.
    - Seeds must be < cfg_mod; seeds ≥ cfg_mod are undefined behaviour and are not checked.
  - Mode 2: f = sum[SEQ_BITS-1:0] and b_vld <= b_vld && !c.
    - When a_vld becomes 0, the generator is exhausted: done = 1, req_ready = 0 until the next load or reset.
- ovf: set on any accept where c = 1, in every mode; sticky until load or reset.
  - In mode 1, c is the carry out of the raw sum before reduction.
- Output hold:
  - While out_valid && !out_ready, out_data and out_idx hold stable.
  - out_valid clears on out_ready unless a new accept happens in the same cycle (back-to-back throughput of one term per cycle).
  - out_ready alone never changes internal state.
- Simultaneous events:
  - load with req: load wins; req is not consumed (req_ready = 0).
  - load with out_ready: load wins; the output is dropped.
  - rst_n = 0 beats load.
- Implementation: FSM with states IDLE_OR_RUN (a_vld = 1) and DONE (a_vld = 0, mode 2).
  - RUN → DONE on an accept where b_vld = 0.
  - DONE → RUN on load.

Test Plan:
- Reset, no load, req held high, out_ready = 1, SEQ_BITS = 8 → out_data 0,1,1,2,3,5,8,13 with out_idx 0..7, one term per cycle after one cycle of latency; done = 0, ovf = 0.
- Load seeds 2,1 (Lucas), mode 0 → 2,1,3,4,7,11,18. Continue a Fibonacci run in mode 0, SEQ_BITS = 8 → idx 13 = 233, idx 14 = 121 (377 mod 256), ovf rises on the accept that computes 377.
- Mode 2, seeds 0,1, SEQ_BITS = 8, req high → 14 terms ending with 233 at idx 13. done = 1 after the last accept; req_ready = 0; out_valid clears after the consumer accepts 233; further req ignored.
- Mode 1, modulus 10, seeds 0,1 → 0,1,1,2,3,5,8,3,1,4,5,9,4,3; ovf stays 0.
- Backpressure: out_ready low for 3 cycles after the term 5 → out_data = 5 and out_idx = 5 stable, req_ready = 0, no term skipped; release gives 8 next.
- Load pulse during a stall, then rst_n low mid-run → pending output dropped, idx restarts at 0 with the new seeds; after reset all outputs are 0 and the sequence restarts 0,1,1.

Source files
------------

// File: rtl/recur_seq_gen.sv
// rtl/recur_seq_gen.sv - second-order recurrence generator (t[n+2] = t[n+1] + t[n])
// with programmable seeds, wrap/modular/stop-on-overflow arithmetic and ready/valid output.
module recur_seq_gen #(
  parameter int SEQ_BITS = 32,
  parameter int IDX_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SEQ_BITS-1:0] seed0,
  input  logic [SEQ_BITS-1:0] seed1,
  input  logic [1:0]          mode,
  input  logic [SEQ_BITS-1:0] modulus,
  input  logic                req,
  output logic                req_ready,
  output logic [SEQ_BITS-1:0] out_data,
  output logic [IDX_BITS-1:0] out_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done,
  output logic                ovf
);

  typedef enum logic {S_RUN, S_DONE} state_t;

  state_t              state;
  logic [SEQ_BITS-1:0] a, b;
  logic                b_vld;
  logic [IDX_BITS-1:0] idx;
  logic [1:0]          cfg_mode;
  logic [SEQ_BITS-1:0] cfg_mod;

  logic                a_vld;
  logic                accept;
  logic [SEQ_BITS:0]   sum;
  logic [SEQ_BITS:0]   mod_ext;
  logic                carry;
  logic [SEQ_BITS-1:0] next_b;

  assign a_vld     = (state == S_RUN);
  assign req_ready = !load && a_vld && (!out_valid || out_ready);
  assign accept    = req && req_ready;

  // A zero modulus stands for 2^SEQ_BITS, which reduces to plain wrapping.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    carry   = sum[SEQ_BITS];
    mod_ext = (cfg_mod == '0) ? {1'b1, {SEQ_BITS{1'b0}}} : {1'b0, cfg_mod};
    next_b  = sum[SEQ_BITS-1:0];
    if (cfg_mode == 2'd1 && sum >= mod_ext) begin
      next_b = SEQ_BITS'(sum - mod_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      a         <= '0;
      b         <= SEQ_BITS'(1);
      b_vld     <= 1'b1;
      idx       <= '0;
      cfg_mode  <= 2'd0;
      cfg_mod   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else if (load) begin
      state     <= S_RUN;
      a         <= seed0;
      b         <= seed1;
      b_vld     <= 1'b1;
      idx       <= '0;
      cfg_mode  <= mode;
      cfg_mod   <= modulus;
      out_valid <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= a;
      out_idx   <= idx;
      a         <= b;
      b         <= next_b;
      idx       <= idx + IDX_BITS'(1);
      if (carry) ovf <= 1'b1;
      // Only stop mode invalidates a term on carry; other modes keep b_vld high.
      if (cfg_mode == 2'd2 && carry) b_vld <= 1'b0;
      if (!b_vld) begin
        state <= S_DONE;
        done  <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_recur_seq_gen.sv
// tb/tb_recur_seq_gen.sv - directed self-checking bench for recur_seq_gen at SEQ_BITS = 8.
module tb_recur_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [7:0]  seed0, seed1, modulus;
  logic [1:0]  mode;
  logic        req;
  logic        req_ready;
  logic [7:0]  out_data;
  logic [15:0] out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  recur_seq_gen #(.SEQ_BITS(8), .IDX_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .seed0(seed0), .seed1(seed1),
    .mode(mode), .modulus(modulus), .req(req), .req_ready(req_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [1:0] m, input logic [7:0] md);
    load = 1'b1; seed0 = s0; seed1 = s1; mode = m; modulus = md;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_d [0:7];
    exp_d = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
    rst_n = 1'b0; load = 1'b0; req = 1'b0; out_ready = 1'b1;
    seed0 = '0; seed1 = '0; mode = '0; modulus = '0;
    tick(); tick();
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 16'd0 || done !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%0d i=%0d done=%b ovf=%b, want all 0",
               out_valid, out_data, out_idx, done, ovf);
    end
    rst_n = 1'b1; req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_idx !== 16'(i)) begin
        bad++;
        $display("FAIL reset_seq[%0d]: got v=%b d=%0d i=%0d, want v=1 d=%0d i=%0d",
                 i, out_valid, out_data, out_idx, exp_d[i], i);
      end
    end
    total++;
    if (done !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got done=%b ovf=%b, want 0 0", done, ovf);
    end
    req = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] luc [0:6];
    logic [7:0] fib [0:14];
    luc = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7, 8'd11, 8'd18};
    fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
            8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
    out_ready = 1'b1;
    do_load(8'd2, 8'd1, 2'd0, 8'd0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL lucas_load_clear: got v=%b, want 0", out_valid);
    end
    req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== luc[i] || out_idx !== 16'(i)) begin
        bad++;
        $display("FAIL lucas[%0d]: got v=%b d=%0d i=%0d, want d=%0d i=%0d",
                 i, out_valid, out_data, out_idx, luc[i], i);
      end
    end
    req = 1'b0;
    do_load(8'd0, 8'd1, 2'd0, 8'd0);
    req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      total++;
      if (out_data !== fib[i] || out_idx !== 16'(i) || ovf !== (i >= 12)) begin
        bad++;
        $display("FAIL fib_wrap[%0d]: got d=%0d i=%0d ovf=%b, want d=%0d i=%0d ovf=%b",
                 i, out_data, out_idx, ovf, fib[i], i, (i >= 12));
      end
    end
    req = 1'b0;
  endtask

  task automatic test_stop_mode();
    logic [7:0] fib [0:13];
    fib = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
            8'd55, 8'd89, 8'd144, 8'd233};
    out_ready = 1'b1;
    do_load(8'd0, 8'd1, 2'd2, 8'd0);
    req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== fib[i] || out_idx !== 16'(i) || done !== (i == 13)) begin
        bad++;
        $display("FAIL stop[%0d]: got v=%b d=%0d i=%0d done=%b, want v=1 d=%0d i=%0d done=%b",
                 i, out_valid, out_data, out_idx, done, fib[i], i, (i == 13));
      end
    end
    total++;
    if (req_ready !== 1'b0 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL stop_exhausted: got req_ready=%b ovf=%b, want 0 1", req_ready, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || done !== 1'b1 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stop_idle[%0d]: got v=%b done=%b rr=%b, want 0 1 0",
                 i, out_valid, done, req_ready);
      end
    end
    req = 1'b0;
  endtask

  task automatic test_modular();
    logic [7:0] exp_d [0:13];
    exp_d = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd3, 8'd1, 8'd4,
              8'd5, 8'd9, 8'd4, 8'd3};
    out_ready = 1'b1;
    do_load(8'd0, 8'd1, 2'd1, 8'd10);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL mod_load_done: got done=%b, want 0", done);
    end
    req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      total++;
      if (out_data !== exp_d[i] || out_idx !== 16'(i)) begin
        bad++;
        $display("FAIL mod10[%0d]: got d=%0d i=%0d, want d=%0d i=%0d",
                 i, out_data, out_idx, exp_d[i], i);
      end
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL mod10_ovf: got %b, want 0", ovf);
    end
    req = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    do_load(8'd0, 8'd1, 2'd0, 8'd0);
    req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'd5 || out_idx !== 16'd5 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall[%0d]: got v=%b d=%0d i=%0d rr=%b, want 1 5 5 0",
                 i, out_valid, out_data, out_idx, req_ready);
      end
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd8 || out_idx !== 16'd6) begin
      bad++;
      $display("FAIL stall_release: got v=%b d=%0d i=%0d, want 1 8 6", out_valid, out_data, out_idx);
    end
    req = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    do_load(8'd0, 8'd1, 2'd0, 8'd0);
    req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    out_ready = 1'b0;
    tick();
    // load while the idx 2 term sits unaccepted; it must be dropped
    do_load(8'd5, 8'd7, 2'd0, 8'd0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_drop: got v=%b, want 0", out_valid);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'd5 || out_idx !== 16'd0) begin
      bad++;
      $display("FAIL load_restart0: got v=%b d=%0d i=%0d, want 1 5 0", out_valid, out_data, out_idx);
    end
    tick();
    total++;
    if (out_data !== 8'd7 || out_idx !== 16'd1) begin
      bad++;
      $display("FAIL load_restart1: got d=%0d i=%0d, want 7 1", out_data, out_idx);
    end
    rst_n = 1'b0; load = 1'b1; seed0 = 8'd9; seed1 = 8'd9;
    tick();
    load = 1'b0; req = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 16'd0 || done !== 1'b0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got v=%b d=%0d i=%0d done=%b ovf=%b, want all 0",
               out_valid, out_data, out_idx, done, ovf);
    end
    rst_n = 1'b1; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_data !== ((i == 0) ? 8'd0 : 8'd1) || out_idx !== 16'(i)) begin
        bad++;
        $display("FAIL post_reset[%0d]: got d=%0d i=%0d, want d=%0d i=%0d",
                 i, out_data, out_idx, (i == 0) ? 0 : 1, i);
      end
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stop_mode();
    test_modular();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
